// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for pipelined_adder.
// The master side drives operands and the advance enable; the slave produces results.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    modport master (
        output en, in_valid, A, B, Cin,
        input  out_valid, S, Cout, Ovf
    );

    modport slave (
        input  en, in_valid, A, B, Cin,
        output out_valid, S, Cout, Ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Segmented carry-chain adder for the MAC accumulate path.
// Each stage adds one SEG-bit slice; upper operands skew forward, lower sums trail.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int SAT    = 0
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave io
);
    localparam int SEG = WIDTH / STAGES;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             vld_q;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad
        $error("pipelined_adder: WIDTH must be a multiple of STAGES >= 1");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int OPW = WIDTH - k * SEG;
        localparam int LOW = k * SEG;

        logic [OPW-1:0]     a_in;
        logic [OPW-1:0]     b_in;
        logic               c_in;
        logic               v_in;
        logic [SEG:0]       seg_sum;
        logic [LOW+SEG-1:0] s_nxt;

        if (k == 0) begin : g_head
            assign a_in  = io.A;
            assign b_in  = io.B;
            assign c_in  = io.Cin;
            assign v_in  = io.in_valid;
            assign s_nxt = seg_sum[SEG-1:0];
        end else begin : g_tail
            assign a_in  = g_st[k-1].g_reg.a_q;
            assign b_in  = g_st[k-1].g_reg.b_q;
            assign c_in  = g_st[k-1].g_reg.c_q;
            assign v_in  = g_st[k-1].g_reg.v_q;
            assign s_nxt = {seg_sum[SEG-1:0], g_st[k-1].g_reg.s_q};
        end

        assign seg_sum = {1'b0, a_in[SEG-1:0]}
                       + {1'b0, b_in[SEG-1:0]}
                       + {{SEG{1'b0}}, c_in};

        if (k < STAGES - 1) begin : g_reg
            logic [OPW-SEG-1:0] a_q;
            logic [OPW-SEG-1:0] b_q;
            logic [LOW+SEG-1:0] s_q;
            logic               c_q;
            logic               v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (io.en) begin
                    a_q <= a_in[OPW-1:SEG];
                    b_q <= b_in[OPW-1:SEG];
                    s_q <= s_nxt;
                    c_q <= seg_sum[SEG];
                    v_q <= v_in;
                end
            end
        end else begin : g_out
            // Only the MSB slice remains here, so a_in/b_in top bits are the sign bits.
            logic             ovf;
            logic [WIDTH-1:0] sat_val;

            assign ovf = (a_in[SEG-1] == b_in[SEG-1])
                      && (s_nxt[WIDTH-1] != a_in[SEG-1]);
            assign sat_val = a_in[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};

            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    vld_q  <= 1'b0;
                end else if (io.en) begin
                    sum_q  <= (SAT != 0 && ovf) ? sat_val : s_nxt;
                    cout_q <= seg_sum[SEG];
                    ovf_q  <= ovf;
                    vld_q  <= v_in;
                end
            end
        end
    end

    assign io.out_valid = vld_q;
    assign io.S         = sum_q;
    assign io.Cout      = cout_q;
    assign io.Ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four configurations share one stimulus stream
// and are scored against an arithmetic reference with per-operation due times.
module tb_pipelined_adder;
    logic clk;
    logic rst;

    pipelined_adder_if #(.WIDTH(16)) i0 ();
    pipelined_adder_if #(.WIDTH(16)) i1 ();
    pipelined_adder_if #(.WIDTH(8))  i2 ();
    pipelined_adder_if #(.WIDTH(32)) i3 ();

    pipelined_adder #(.WIDTH(16), .STAGES(2), .SAT(0)) u0 (.clk(clk), .rst(rst), .io(i0));
    pipelined_adder #(.WIDTH(16), .STAGES(4), .SAT(1)) u1 (.clk(clk), .rst(rst), .io(i1));
    pipelined_adder #(.WIDTH(8),  .STAGES(1), .SAT(0)) u2 (.clk(clk), .rst(rst), .io(i2));
    pipelined_adder #(.WIDTH(32), .STAGES(8), .SAT(1)) u3 (.clk(clk), .rst(rst), .io(i3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] o_s [4];
    logic        o_v [4];
    logic        o_c [4];
    logic        o_f [4];

    assign o_s[0] = 32'(i0.S);
    assign o_s[1] = 32'(i1.S);
    assign o_s[2] = 32'(i2.S);
    assign o_s[3] = i3.S;
    assign o_v[0] = i0.out_valid;
    assign o_v[1] = i1.out_valid;
    assign o_v[2] = i2.out_valid;
    assign o_v[3] = i3.out_valid;
    assign o_c[0] = i0.Cout;
    assign o_c[1] = i1.Cout;
    assign o_c[2] = i2.Cout;
    assign o_c[3] = i3.Cout;
    assign o_f[0] = i0.Ovf;
    assign o_f[1] = i1.Ovf;
    assign o_f[2] = i2.Ovf;
    assign o_f[3] = i3.Ovf;

    int errors = 0;
    int checks = 0;

    // Reference state: queued results with the enabled-edge index they are due at.
    int unsigned due_r [4][64];
    logic [31:0] s_r   [4][64];
    logic        c_r   [4][64];
    logic        f_r   [4][64];
    int          hd    [4];
    int          tl    [4];
    int unsigned en_edges = 0;

    logic        exp_v [4];
    logic [31:0] exp_s [4];
    logic        exp_c [4];
    logic        exp_f [4];
    bit          known [4];

    function automatic int wid(input int d);
        case (d)
            0: return 16;
            1: return 16;
            2: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int stg(input int d);
        case (d)
            0: return 2;
            1: return 4;
            2: return 1;
            default: return 8;
        endcase
    endfunction

    function automatic bit satm(input int d);
        return d == 1 || d == 3;
    endfunction

    // {Cout, Ovf, S} from integer arithmetic on the operands' unsigned and signed values.
    function automatic logic [33:0] ref_add(input int d, input logic [31:0] a, b,
                                            input logic ci);
        int     w    = wid(d);
        longint full = longint'(64'd1) <<< w;
        longint m    = full - 1;
        longint half = full >>> 1;
        longint ua   = longint'(a) & m;
        longint ub   = longint'(b) & m;
        longint tot  = ua + ub + longint'(ci);
        longint sa   = (ua >= half) ? ua - full : ua;
        longint sb   = (ub >= half) ? ub - full : ub;
        longint ss   = sa + sb + longint'(ci);
        longint hi   = half - 1;
        longint lo   = -half;
        logic   ov   = (ss > hi) || (ss < lo);
        logic   co   = tot[w];
        longint s    = tot & m;
        if (satm(d) && ov) s = (ss > hi) ? hi : (lo & m);
        return {co, ov, s[31:0]};
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s d%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, e, v, input logic [31:0] a, b, input logic ci);
        logic [33:0] rr;
        if (r) begin
            for (int d = 0; d < 4; d++) begin
                hd[d] = 0;
                tl[d] = 0;
                exp_v[d] = 1'b0;
                exp_s[d] = '0;
                exp_c[d] = 1'b0;
                exp_f[d] = 1'b0;
                known[d] = 1'b1;
            end
        end else if (e) begin
            en_edges++;
            for (int d = 0; d < 4; d++) begin
                if (v) begin
                    rr = ref_add(d, a, b, ci);
                    due_r[d][tl[d]] = en_edges + stg(d) - 1;
                    s_r[d][tl[d]] = rr[31:0];
                    c_r[d][tl[d]] = rr[33];
                    f_r[d][tl[d]] = rr[32];
                    tl[d] = (tl[d] + 1) % 64;
                end
                if (hd[d] != tl[d] && due_r[d][hd[d]] == en_edges) begin
                    exp_v[d] = 1'b1;
                    exp_s[d] = s_r[d][hd[d]];
                    exp_c[d] = c_r[d][hd[d]];
                    exp_f[d] = f_r[d][hd[d]];
                    known[d] = 1'b1;
                    hd[d] = (hd[d] + 1) % 64;
                end else begin
                    exp_v[d] = 1'b0;
                    known[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic r, e, v, input logic [31:0] a, b, input logic ci);
        rst = r;
        i0.en = e; i1.en = e; i2.en = e; i3.en = e;
        i0.in_valid = v; i1.in_valid = v; i2.in_valid = v; i3.in_valid = v;
        i0.A = a[15:0]; i1.A = a[15:0]; i2.A = a[7:0]; i3.A = a;
        i0.B = b[15:0]; i1.B = b[15:0]; i2.B = b[7:0]; i3.B = b;
        i0.Cin = ci; i1.Cin = ci; i2.Cin = ci; i3.Cin = ci;
        @(posedge clk);
        model_edge(r, e, v, a, b, ci);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("out_valid", d, 32'(o_v[d]), 32'(exp_v[d]));
            if (known[d]) begin
                chk("S", d, o_s[d], exp_s[d]);
                chk("Cout", d, 32'(o_c[d]), 32'(exp_c[d]));
                chk("Ovf", d, 32'(o_f[d]), 32'(exp_f[d]));
            end
        end
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
    endtask

    int pulses;

    initial begin
        for (int d = 0; d < 4; d++) begin
            hd[d] = 0;
            tl[d] = 0;
            known[d] = 1'b0;
        end
        step(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Carry across the segment boundary
        step(1'b0, 1'b1, 1'b1, 32'h00FF, 32'h0001, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("plan_carry_v", 0, 32'(o_v[0]), 32'h1);
        chk("plan_carry_s", 0, o_s[0], 32'h0100);
        bubbles(8);

        // Back-to-back stream, wrap and saturate
        step(1'b0, 1'b1, 1'b1, 32'hFFFF, 32'h0001, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h7FFF, 32'h0001, 1'b0);
        chk("b2b_s0", 0, o_s[0], 32'h0000);
        chk("b2b_c0", 0, 32'(o_c[0]), 32'h1);
        chk("b2b_f0", 0, 32'(o_f[0]), 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h1234, 32'h4321, 1'b1);
        chk("b2b_s1", 0, o_s[0], 32'h8000);
        chk("b2b_f1", 0, 32'(o_f[0]), 32'h1);
        chk("b2b_c1", 0, 32'(o_c[0]), 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h8000, 32'hFFFF, 1'b0);
        chk("b2b_s2", 0, o_s[0], 32'h5556);
        chk("lat4_v", 1, 32'(o_v[1]), 32'h1);
        chk("lat4_s", 1, o_s[1], 32'h0000);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("sat_pos_s", 1, o_s[1], 32'h7FFF);
        chk("sat_pos_f", 1, 32'(o_f[1]), 32'h1);
        chk("sat_pos_c", 1, 32'(o_c[1]), 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("sat_neg_s", 1, o_s[1], 32'h8000);
        chk("sat_neg_f", 1, 32'(o_f[1]), 32'h1);
        chk("sat_neg_c", 1, 32'(o_c[1]), 32'h1);
        bubbles(8);

        // Stall mid-stream
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            if (o_v[0]) pulses++;
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, $urandom, $urandom, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
            if (o_v[0]) pulses++;
        end
        chk("stall_pulses", 0, 32'(pulses), 32'd3);

        // Reset flush with ops in flight and a same-cycle input
        step(1'b0, 1'b1, 1'b1, $urandom, $urandom, 1'b0);
        step(1'b0, 1'b1, 1'b1, $urandom, $urandom, 1'b1);
        step(1'b1, 1'b1, 1'b1, $urandom, $urandom, 1'b1);
        chk("flush_v", 1, 32'(o_v[1]), 32'h0);
        chk("flush_s", 3, o_s[3], 32'h0);
        bubbles(10);

        // Bubble pattern through the single-stage adder
        step(1'b0, 1'b1, 1'b1, 32'h5A, 32'h33, 1'b1);
        chk("bub_v1", 2, 32'(o_v[2]), 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h11, 32'h22, 1'b0);
        chk("bub_v0", 2, 32'(o_v[2]), 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h7F, 32'h01, 1'b0);
        chk("bub_v2", 2, 32'(o_v[2]), 32'h1);
        bubbles(8);

        // Random sweep with stalls, bubbles and occasional resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 3) != 0),
                 $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        bubbles(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
